// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the ALU pipe.
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam int FLG_C = 0;
  localparam int FLG_L = 2;
  localparam int FLG_F = 5;
  localparam int FLG_Z = 6;
  localparam int FLG_N = 7;

  // implemented flag bits; the rest always read 0
  localparam logic [7:0] FLG_MASK = 8'b1110_0101;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, HOLD} state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between an ALU client and alu_pipe.
interface alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rout;
  logic [7:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, opcode, r1, r2, out_ready,
    input  in_ready, out_valid, rout, flags, illegal
  );

  modport slave (
    input  in_valid, opcode, r1, r2, out_ready,
    output in_ready, out_valid, rout, flags, illegal
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: loads on start, runs exactly WIDTH steps, done on the last.
// product is valid in the cycle done is high (it is the post-final-step accumulator).
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             busy;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH-1));
  assign product = acc_nxt;

  // one partial product per cycle; reset drops any job in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with valid/ready in and out, persistent flags and an
// optional iterative multiplier. One operation in flight at a time.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [7:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rout_q;
  logic [7:0]       flags_q;
  logic             illegal_q, in_ready_q, out_valid_q;

  logic             accept, is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign accept = bus.in_valid && in_ready_q;
  assign is_mul = (MUL_EN != 0) && (bus.opcode == OP_MUL);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rout      = rout_q;
  assign bus.flags     = flags_q & FLG_MASK;
  assign bus.illegal   = illegal_q;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (bus.r1),
        .b       (bus.r2),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  logic [WIDTH-1:0] ex_res;
  logic [7:0]       ex_flags;
  logic             ex_ill, cin, sh_big;
  logic [WIDTH:0]   sum_add, sum_sub;

  // single-cycle datapath on the latched operands; carry-in is the C held since acceptance
  always_comb begin
    ex_res   = '0;
    ex_flags = flags_q;
    ex_ill   = 1'b0;
    cin      = (op_q == OP_ADDC) && flags_q[FLG_C];
    sum_add  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    sh_big   = (a_q >= WIDTH'(WIDTH));
    case (op_q)
      OP_ADD, OP_ADDC: begin
        ex_res          = sum_add[MSB:0];
        ex_flags[FLG_C] = sum_add[WIDTH];
        ex_flags[FLG_F] = (a_q[MSB] == b_q[MSB]) && (sum_add[MSB] != a_q[MSB]);
      end
      OP_ADDU: ex_res = sum_add[MSB:0];
      OP_SUB: begin
        ex_res          = sum_sub[MSB:0];
        ex_flags[FLG_C] = sum_sub[WIDTH];
        ex_flags[FLG_F] = (a_q[MSB] != b_q[MSB]) && (sum_sub[MSB] != a_q[MSB]);
      end
      OP_CMP: begin
        ex_res          = sum_sub[MSB:0];
        ex_flags[FLG_Z] = (a_q == b_q);
        ex_flags[FLG_L] = (a_q < b_q);
        ex_flags[FLG_N] = ($signed(a_q) < $signed(b_q));
      end
      OP_AND:          ex_res = a_q & b_q;
      OP_OR:           ex_res = a_q | b_q;
      OP_XOR:          ex_res = a_q ^ b_q;
      OP_NOT:          ex_res = ~a_q;
      OP_LSH, OP_ALSH: ex_res = sh_big ? '0 : (b_q << a_q);
      OP_RSH:          ex_res = sh_big ? '0 : (b_q >> a_q);
      OP_ARSH:         ex_res = sh_big ? {WIDTH{b_q[MSB]}} : WIDTH'($signed(b_q) >>> a_q);
      default:         ex_ill = 1'b1;
    endcase
  end

  // control FSM; all outputs registered, flags only written on the EXEC edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rout_q      <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= bus.opcode;
            a_q        <= bus.r1;
            b_q        <= bus.r2;
            in_ready_q <= 1'b0;
            state      <= is_mul ? MUL : EXEC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        EXEC: begin
          rout_q      <= ex_res;
          flags_q     <= ex_flags;
          illegal_q   <= ex_ill;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        MUL: begin
          if (mul_done) begin
            rout_q      <= mul_prod;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed + random bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 16;
  localparam longint FULL = 64'sd1 << W;
  localparam longint HALF = 64'sd1 << (W - 1);
  localparam longint MSK  = FULL - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   checks = 0;
  logic [7:0] mfl;                 // model flag register
  logic [W-1:0] lr;                // last observed rout
  logic [7:0]   lf;                // last observed flags
  logic [7:0]   ops [15];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  function automatic bit ovf(input longint s);
    return (s > HALF - 1) || (s < -HALF);
  endfunction

  // what each opcode means, in plain integer arithmetic
  function automatic void model(input logic [7:0] op, input longint a, input longint b,
                                inout logic [7:0] fl, output longint res, output bit ill);
    longint s;
    ill = 1'b0;
    res = 0;
    case (op)
      8'h05, 8'h07: begin
        s     = a + b + ((op == 8'h07) ? longint'(fl[0]) : 0);
        res   = s & MSK;
        fl[0] = (s > MSK);
        fl[5] = ovf(sgn(a) + sgn(b) + ((op == 8'h07) ? longint'(fl[0] ^ (s > MSK)) * 0 + (s - a - b) : 0));
      end
      8'h06: res = (a + b) & MSK;
      8'h09: begin
        res   = (a - b) & MSK;
        fl[0] = (a >= b);
        fl[5] = ovf(sgn(a) - sgn(b));
      end
      8'h0B: begin
        res   = (a - b) & MSK;
        fl[6] = (a == b);
        fl[2] = (a < b);
        fl[7] = (sgn(a) < sgn(b));
      end
      8'h01: res = a & b;
      8'h02: res = a | b;
      8'h03: res = a ^ b;
      8'h04: res = (~a) & MSK;
      8'h84, 8'h0C: res = (a >= W) ? 0 : ((b << a) & MSK);
      8'h08: res = (a >= W) ? 0 : (b >> a);
      8'h0F: res = (a >= W) ? ((sgn(b) < 0) ? MSK : 0) : ((sgn(b) >>> a) & MSK);
      8'h0E: res = (a * b) & MSK;
      default: ill = 1'b1;
    endcase
  endfunction

  // offer one operation, check timing and result, hold the result 'hold' cycles, then drain
  task automatic run_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int n;
    longint res;
    bit eill;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.r1       = a;
    bus.r2       = b;
    @(posedge clk); #1;
    vectors++;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.opcode   = 8'($urandom);
    bus.r1       = W'($urandom);
    bus.r2       = W'($urandom);
    model(op, longint'(a), longint'(b), mfl, res, eill);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n + 1), (op == 8'h0E) ? 64'(W + 1) : 64'd2);
    check("rout", 64'(bus.rout), 64'(res));
    check("illegal", 64'(bus.illegal), 64'(eill));
    check("flags", 64'(bus.flags), 64'(mfl));
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_rout", 64'(bus.rout), 64'(res));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_flags", 64'(bus.flags), 64'(mfl));
    end
    lr = bus.rout;
    lf = bus.flags;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int k;
    logic [7:0] op;
    logic [W-1:0] a, b;
    ops = '{8'h05, 8'h06, 8'h07, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03,
            8'h04, 8'h84, 8'h08, 8'h0C, 8'h0F, 8'h0E, 8'h00};
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = '0; bus.r1 = '0; bus.r2 = '0;
    mfl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rout", 64'(bus.rout), 64'd0);
    check("rst_flags", 64'(bus.flags), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(8'h05, 16'h7FFF, 16'h0001, 1);
    check("add_ovf_rout", 64'(lr), 64'h8000);
    check("add_ovf_F", 64'(lf[5]), 64'd1);
    check("add_ovf_C", 64'(lf[0]), 64'd0);
    run_op(8'h05, 16'hFFFF, 16'h0001, 0);
    check("add_wrap_rout", 64'(lr), 64'h0000);
    check("add_wrap_C", 64'(lf[0]), 64'd1);
    run_op(8'h07, 16'h0001, 16'h0001, 0);
    check("addc_rout", 64'(lr), 64'h0003);
    check("addc_C", 64'(lf[0]), 64'd0);
    run_op(8'h0B, 16'hFFFE, 16'h0001, 0);
    check("cmp1_ZLN", 64'({lf[6], lf[2], lf[7]}), 64'b001);
    run_op(8'h0B, 16'h0005, 16'h0005, 0);
    check("cmp2_ZLN", 64'({lf[6], lf[2], lf[7]}), 64'b100);
    run_op(8'h0E, 16'h0123, 16'h0010, 5);
    check("mul_rout", 64'(lr), 64'h1230);
    run_op(8'h0F, 16'd20, 16'h8000, 0);
    check("arsh_big", 64'(lr), 64'hFFFF);
    run_op(8'h84, 16'd15, 16'h0001, 0);
    check("lsh_15", 64'(lr), 64'h8000);
    k = int'(lf);
    run_op(8'hAA, 16'h1234, 16'h5678, 1);
    check("illegal_rout", 64'(lr), 64'd0);
    check("illegal_flags", 64'(lf), 64'(k));

    // reset during the 8th multiply cycle: the job must vanish
    while (!bus.in_ready) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.opcode = 8'h0E; bus.r1 = 16'h00FF; bus.r2 = 16'h00FF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mfl = '0;
    k = 0;
    repeat (30) begin
      if (bus.out_valid) k++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", 64'(k), 64'd0);
    check("abort_flags", 64'(bus.flags), 64'd0);
    check("abort_rout", 64'(bus.rout), 64'd0);
    run_op(8'h05, 16'd2, 16'd3, 0);
    check("post_abort_add", 64'(lr), 64'h0005);

    repeat (60) begin
      k  = int'($urandom_range(0, 14));
      op = (k == 14) ? 8'($urandom) : ops[k];
      a  = W'($urandom);
      b  = W'($urandom);
      if ((op == 8'h84 || op == 8'h08 || op == 8'h0C || op == 8'h0F) && ($urandom_range(0, 3) != 0))
        a = W'($urandom_range(0, 20));
      run_op(op, a, b, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
